// File: rtl/fw_loader_pkg.sv
// fw_loader_pkg: shared types and constants for the firmware loader.
//   state_t        - loader FSM states
//   BYTES_PER_WORD - stream bytes packed into one instruction word
//   LANE_W         - width of the byte-lane counter
package fw_loader_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/fw_loader_byte_packer.sv
// byte_packer: little-endian assembly register for the firmware loader.
//   clk, reset - clock, async active-high reset
//   clr        - clear word and lane counter (wins over load)
//   load       - write data into lane byte_cnt and advance byte_cnt
//   data       - incoming stream byte
//   word       - assembled 32-bit word (unfilled lanes stay 0)
//   byte_cnt   - next lane to fill (lane 0 = bits 7:0)
module byte_packer
  import fw_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [31:0]       word,
  output logic [LANE_W-1:0] byte_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word[8*int'(byte_cnt) +: 8] <= data;
      byte_cnt                    <= byte_cnt + {{(LANE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fw_loader.sv
// fw_loader: streams a firmware image into instruction memory and controls
// processor reset.
//   clk, reset          - clock, async active-high reset
//   in_valid/in_ready   - byte-stream handshake; in_data byte, in_last ends image
//   restart             - in HALT or ERR, start a new load
//   trap                - processor trap (level); rising edge in RUN halts
//   im_w_en/addr/data   - instruction-memory write port, one strobe per word
//   cpu_reset_n         - active-low processor reset, released only in RUN
//   words_loaded        - words written in the current load
//   halted, err         - state is HALT / ERR
module fw_loader
  import fw_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              restart,
  input  logic              trap,
  output logic              im_w_en,
  output logic [ADDR_W-1:0] im_w_addr,
  output logic [31:0]       im_w_data,
  output logic              cpu_reset_n,
  output logic [ADDR_W:0]   words_loaded,
  output logic              halted,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     word_cnt;
  logic                last_seen;
  logic                trap_q;
  logic                xfer;
  logic                pk_load, pk_clr;
  logic                wc_inc, wc_clr;
  logic                ls_set;
  logic [31:0]         pk_word;
  logic [LANE_W-1:0]   byte_cnt;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (pk_clr),
    .load     (pk_load),
    .data     (in_data),
    .word     (pk_word),
    .byte_cnt (byte_cnt)
  );

  // ERR keeps in_ready high so a stuck source drains instead of stalling.
  assign in_ready     = (state_q == S_LOAD) || (state_q == S_ERR);
  assign xfer         = in_valid && in_ready;
  assign im_w_en      = (state_q == S_WRITE);
  assign im_w_addr    = im_w_en ? word_cnt[ADDR_W-1:0] : '0;
  assign im_w_data    = im_w_en ? pk_word : '0;
  assign cpu_reset_n  = (state_q == S_RUN);
  assign halted       = (state_q == S_HALT);
  assign err          = (state_q == S_ERR);
  assign words_loaded = word_cnt;

  always_comb begin
    state_d = state_q;
    pk_load = 1'b0;
    pk_clr  = 1'b0;
    wc_inc  = 1'b0;
    wc_clr  = 1'b0;
    ls_set  = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (xfer) begin
          if (word_cnt == MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            pk_load = 1'b1;
            if ((byte_cnt == LANE_W'(BYTES_PER_WORD - 1)) || in_last) begin
              state_d = S_WRITE;
              ls_set  = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        wc_inc  = 1'b1;
        pk_clr  = 1'b1;
        state_d = last_seen ? S_RUN : S_LOAD;
      end
      S_RUN: begin
        if (trap && !trap_q) state_d = S_HALT;
      end
      S_HALT, S_ERR: begin
        if (restart) begin
          state_d = S_LOAD;
          wc_clr  = 1'b1;
          pk_clr  = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // trap_q tracks trap every cycle, so on RUN entry it already holds the
  // level seen during the WRITE cycle and a pre-existing trap cannot halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      word_cnt  <= '0;
      last_seen <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap;
      if (wc_clr) begin
        word_cnt  <= '0;
        last_seen <= 1'b0;
      end else if (wc_inc) begin
        word_cnt <= word_cnt + ONE_WORD;
      end
      if (ls_set) last_seen <= in_last;
    end
  end

endmodule

// File: tb/tb_fw_loader.sv
module tb_fw_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        restart;
  logic        trap;

  logic        a_in_ready, a_w_en, a_cpu_reset_n, a_halted, a_err;
  logic [9:0]  a_w_addr;
  logic [31:0] a_w_data;
  logic [10:0] a_words_loaded;

  logic        b_in_ready, b_w_en, b_cpu_reset_n, b_halted, b_err;
  logic [1:0]  b_w_addr;
  logic [31:0] b_w_data;
  logic [2:0]  b_words_loaded;

  int total = 0;
  int bad   = 0;

  int          qa_addr[$];
  logic [31:0] qa_data[$];
  int          qb_addr[$];
  logic [31:0] qb_data[$];

  always #5 clk = ~clk;

  fw_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .restart(restart), .trap(trap),
    .im_w_en(a_w_en), .im_w_addr(a_w_addr), .im_w_data(a_w_data),
    .cpu_reset_n(a_cpu_reset_n), .words_loaded(a_words_loaded),
    .halted(a_halted), .err(a_err)
  );

  fw_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .restart(restart), .trap(trap),
    .im_w_en(b_w_en), .im_w_addr(b_w_addr), .im_w_data(b_w_data),
    .cpu_reset_n(b_cpu_reset_n), .words_loaded(b_words_loaded),
    .halted(b_halted), .err(b_err)
  );

  always @(negedge clk) begin
    if (a_w_en) begin
      qa_addr.push_back(int'(a_w_addr));
      qa_data.push_back(a_w_data);
    end
    if (b_w_en) begin
      qb_addr.push_back(int'(b_w_addr));
      qb_data.push_back(b_w_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clear_queues();
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send(input logic [7:0] b, input logic last, input bit sel);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!(sel ? b_in_ready : a_in_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("send_timeout", 32'h0, 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    restart  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_queues();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data = 8'h00;
    trap    = 1'b0;
    reset   = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
    @(negedge clk);
    // Reset state
    check("rst_w_en",     32'(a_w_en),         32'h0);
    check("rst_addr",     32'(a_w_addr),       32'h0);
    check("rst_data",     a_w_data,            32'h0);
    check("rst_cpu_rstn", 32'(a_cpu_reset_n),  32'h0);
    check("rst_words",    32'(a_words_loaded), 32'h0);
    check("rst_halted",   32'(a_halted),       32'h0);
    check("rst_err",      32'(a_err),          32'h0);
    check("rst_ready",    32'(a_in_ready),     32'h1);
    do_reset();

    // Two full words
    send(8'h13, 0, 0); send(8'h00, 0, 0); send(8'hA0, 0, 0); send(8'hE3, 0, 0);
    check("t1_w0_en", 32'(a_w_en), 32'h1);
    send(8'h01, 0, 0); send(8'h10, 0, 0); send(8'h81, 0, 0); send(8'hE2, 1, 0);
    check("t1_w1_en",      32'(a_w_en),        32'h1);
    check("t1_rstn_write", 32'(a_cpu_reset_n), 32'h0);
    @(negedge clk);
    check("t1_rstn_run", 32'(a_cpu_reset_n),  32'h1);
    check("t1_words",    32'(a_words_loaded), 32'h2);
    check("t1_nwr",      32'(qa_addr.size()), 32'h2);
    if (qa_addr.size() == 2) begin
      check("t1_a0", 32'(qa_addr[0]), 32'h0);
      check("t1_d0", qa_data[0],      32'hE3A00013);
      check("t1_a1", 32'(qa_addr[1]), 32'h1);
      check("t1_d1", qa_data[1],      32'hE2811001);
    end

    // Partial final word
    do_reset();
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 0);
    send(8'h55, 1, 0);
    @(negedge clk);
    check("t2_run",   32'(a_cpu_reset_n),  32'h1);
    check("t2_nwr",   32'(qa_addr.size()), 32'h2);
    if (qa_addr.size() == 2) begin
      check("t2_a0", 32'(qa_addr[0]), 32'h0);
      check("t2_d0", qa_data[0],      32'h44332211);
      check("t2_a1", 32'(qa_addr[1]), 32'h1);
      check("t2_d1", qa_data[1],      32'h00000055);
    end

    // Trap edge halts, restart reloads from address 0
    trap = 1'b1;
    @(negedge clk);
    check("t3_halted", 32'(a_halted),      32'h1);
    check("t3_rstn",   32'(a_cpu_reset_n), 32'h0);
    check("t3_ready",  32'(a_in_ready),    32'h0);
    trap    = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t3_unhalt", 32'(a_halted),       32'h0);
    check("t3_clr",    32'(a_words_loaded), 32'h0);
    clear_queues();
    send(8'hAA, 0, 0); send(8'hBB, 0, 0); send(8'hCC, 0, 0); send(8'hDD, 1, 0);
    check("t3_wen",  32'(a_w_en),   32'h1);
    check("t3_addr", 32'(a_w_addr), 32'h0);
    check("t3_data", a_w_data,      32'hDDCCBBAA);
    @(negedge clk);
    check("t3_words", 32'(a_words_loaded), 32'h1);
    check("t3_run",   32'(a_cpu_reset_n),  32'h1);

    // Trap high across the load must not halt on RUN entry
    do_reset();
    trap = 1'b1;
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 1, 0);
    repeat (4) @(negedge clk);
    check("t4_nohalt", 32'(a_halted),      32'h0);
    check("t4_run",    32'(a_cpu_reset_n), 32'h1);
    trap = 1'b0;
    @(negedge clk);
    trap = 1'b1;
    @(negedge clk);
    check("t4_halt", 32'(a_halted), 32'h1);
    trap = 1'b0;

    // Capacity overflow on the ADDR_W=2 instance
    do_reset();
    for (int i = 0; i < 17; i++) send(8'(i + 1), 0, 1);
    check("t5_err",    32'(b_err),          32'h1);
    check("t5_wen",    32'(b_w_en),         32'h0);
    check("t5_rstn",   32'(b_cpu_reset_n),  32'h0);
    check("t5_ready",  32'(b_in_ready),     32'h1);
    check("t5_words",  32'(b_words_loaded), 32'h4);
    send(8'hF0, 0, 1); send(8'hF1, 0, 1); send(8'hF2, 1, 1);
    @(negedge clk);
    check("t5_err2",  32'(b_err),          32'h1);
    check("t5_nwr",   32'(qb_addr.size()), 32'h4);
    if (qb_addr.size() == 4) begin
      check("t5_d0", qb_data[0],      32'h04030201);
      check("t5_a3", 32'(qb_addr[3]), 32'h3);
      check("t5_d3", qb_data[3],      32'h100F0E0D);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t5_err_clr",   32'(b_err),          32'h0);
    check("t5_words_clr", 32'(b_words_loaded), 32'h0);

    // Reset in the middle of a word
    do_reset();
    send(8'h99, 0, 0); send(8'h88, 0, 0);
    reset = 1'b1;
    #1;
    check("t6_wen",   32'(a_w_en),         32'h0);
    check("t6_rstn",  32'(a_cpu_reset_n),  32'h0);
    check("t6_words", 32'(a_words_loaded), 32'h0);
    check("t6_halt",  32'(a_halted),       32'h0);
    check("t6_err",   32'(a_err),          32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_queues();
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 1, 0);
    @(negedge clk);
    check("t6_nwr", 32'(qa_addr.size()), 32'h1);
    if (qa_addr.size() == 1) begin
      check("t6_a0", 32'(qa_addr[0]), 32'h0);
      check("t6_d0", qa_data[0],      32'h04030201);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fw_loader.md
Name: fw_loader

Overview:
- Hardware counterpart to simulation-time firmware preload. Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes each word into the instruction-memory write port and holds the processor in reset while loading.
- Releases the processor when the stream ends. Re-asserts the processor's reset on a trap.
- Sits between an external byte source (host link / bench driver) and the processor top-level.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high at a clock edge.
- in_data  input  8  stream byte.
- in_last  input  1  marks the final byte of the image; qualified by the transfer.
- restart  input  1  in HALT or ERR, begins a new load.
- trap  input  1  processor trap, level signal.
- im_w_en  output  1  instruction-memory write strobe, one cycle per word.
- im_w_addr  output  ADDR_W  word address.
- im_w_data  output  32  word data.
- cpu_reset_n  output  1  active-low processor reset; 1 only in RUN.
- words_loaded  output  ADDR_W+1  number of words written in the current load.
- halted  output  1  state == HALT.
- err  output  1  state == ERR.

Behaviour:
- States: LOAD, WRITE, RUN, HALT, ERR. All outputs are registered or decoded from state only.
- Reset (async):
  - state = LOAD; byte_cnt = 0; word_cnt = 0; shift register = 0; trap_q = 0; last_seen = 0.
  - Outputs: im_w_en = 0, im_w_addr = 0, im_w_data = 0, cpu_reset_n = 0, words_loaded = 0, halted = 0, err = 0.
- LOAD:
  - in_ready = 1.
  - On a transfer, in_data goes into byte lane byte_cnt (lane 0 = bits 7:0) and byte_cnt increments.
  - If a byte transfers while word_cnt == MAX_WORDS, go to ERR; the byte is discarded.
  - Else if byte_cnt was 3 or in_last = 1, go to WRITE and latch last_seen = in_last.
- WRITE (exactly one cycle):
  - in_ready = 0; im_w_en = 1; im_w_addr = word_cnt[ADDR_W-1:0]; im_w_data = assembled word.
  - Unfilled lanes of a partial final word are 0.
  - At the edge: word_cnt++, byte_cnt = 0, shift register cleared. Go to RUN if last_seen, else LOAD.
- Throughput: a full word takes 4 transfer cycles plus 1 write cycle (4 bytes per 5 cycles at full rate). The write appears in the cycle after the 4th byte transfers.
- RUN:
  - cpu_reset_n = 1, in_ready = 0.
  - trap_q samples trap every cycle. A rising edge (trap & ~trap_q) moves to HALT.
  - A trap already high on RUN entry does not halt; trap_q is loaded with trap on the LOAD/WRITE→RUN transition.
- HALT:
  - cpu_reset_n = 0, halted = 1, in_ready = 0.
  - restart → LOAD; clears word_cnt, words_loaded, byte_cnt.
- ERR:
  - cpu_reset_n = 0, err = 1, in_ready = 1 (drains the source; bytes are discarded and in_last is ignored).
  - restart → LOAD; clears counters.
- Simultaneous events:
  - restart is ignored in LOAD, WRITE and RUN.
  - In HALT or ERR with restart and in_valid together, no byte transfers that cycle (in_ready is decoded from the current state = HALT/ERR drain; an ERR drain byte is dropped).
- words_loaded equals word_cnt. It saturates naturally at MAX_WORDS because ERR blocks further increments.
- Reset mid-load: everything returns to reset values immediately. Partial memory contents are not scrubbed.

Decomposition:
- Package fw_loader_pkg: state enum (LOAD, WRITE, RUN, HALT, ERR) and localparam BYTES_PER_WORD = 4.
- One sub-module, byte_packer: lane-indexed 32-bit assembly register with clear and byte_cnt. It keeps the FSM free of datapath.

Test Plan:
- Stream 8 bytes 0x13,0x00,0xA0,0xE3,0x01,0x10,0x81,0xE2 with in_last on the 8th → writes (0,0xE3A00013), (1,0xE2811001); cpu_reset_n rises the cycle after the 2nd write; words_loaded = 2.
- Stream 5 bytes 0x11,0x22,0x33,0x44,0x55 with in_last on the 5th → writes (0,0x44332211), (1,0x00000055); enters RUN.
- In RUN, pulse trap 0→1 → next cycle halted = 1, cpu_reset_n = 0. Then restart, load 4 bytes → write at address 0; words_loaded = 1.
- trap held high through the whole load → no HALT on RUN entry. Drop trap, re-raise → HALT.
- ADDR_W = 2, stream 17 bytes → 4 writes, then err = 1 on the 17th byte; further bytes are accepted and dropped with no im_w_en.
- Assert reset after 2 bytes of a word → all outputs at reset values. A following 4-byte stream writes address 0 with only the new bytes.
